// File: rtl/quantum_timer_pkg.sv
// Shared encodings for the preemption timer and the control unit's set instructions.
package quantum_timer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SWITCH = 2'd2
   } timerState_t;

   typedef enum logic [1:0] {
      SET_NONE      = 2'd0,
      SET_QUANTUM   = 2'd1,
      SET_MULTIPROG = 2'd2,
      SET_ADDR_CS   = 2'd3
   } setValue_t;

endpackage

// File: rtl/quantum_counter.sv
// Loadable down-counter for the user quantum; flags the last instruction (count == 1).
module quantum_counter #(
   parameter int QUANTUM_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     enable,
   input  logic [QUANTUM_WIDTH-1:0] loadValue,
   output logic                     terminal
);

   localparam logic [QUANTUM_WIDTH-1:0] ONE = QUANTUM_WIDTH'(1);

   logic [QUANTUM_WIDTH-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (enable && count != '0) begin
         count <= count - ONE;
      end
   end

   assign terminal = (count == ONE);

endmodule

// File: rtl/quantum_timer.sv
// Preemption timer: counts the user quantum after EXEC and requests a context switch.
module quantum_timer
   import quantum_timer_pkg::*;
#(
   parameter int ADDR_WIDTH    = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int QUANTUM_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  interruption,
   input  logic [1:0]            flagSetValue,
   input  logic                  flagExecProc,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic [ADDR_WIDTH-1:0] pcCurrent,
   output logic                  flagCS,
   output logic [ADDR_WIDTH-1:0] addrCS,
   output logic [ADDR_WIDTH-1:0] pcProcess,
   output logic                  multiprogOn,
   output logic                  running
);

   timerState_t              state, stateNext;
   setValue_t                setCode;
   logic [QUANTUM_WIDTH-1:0] quantumReg;
   logic                     quantumNonZero;
   logic                     counterLoad;
   logic                     counterEnable;
   logic                     counterTerminal;
   logic                     capturePc;
   logic                     unusedDataBits;

   assign setCode        = setValue_t'(flagSetValue);
   assign quantumNonZero = (quantumReg != '0);
   assign unusedDataBits = ^dataIn[DATA_WIDTH-1:QUANTUM_WIDTH];

   // Set instructions land in any state; a running count keeps its value until the next EXEC.
   always_ff @(posedge clock) begin
      if (reset) begin
         quantumReg  <= '0;
         multiprogOn <= 1'b0;
         addrCS      <= '0;
      end else begin
         case (setCode)
            SET_QUANTUM:   quantumReg  <= dataIn[QUANTUM_WIDTH-1:0];
            SET_MULTIPROG: multiprogOn <= dataIn[0];
            SET_ADDR_CS:   addrCS      <= dataIn[ADDR_WIDTH-1:0];
            default:       ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         pcProcess <= '0;
      end else begin
         state <= stateNext;
         if (capturePc) begin
            pcProcess <= pcCurrent;
         end
      end
   end

   // NOTE: every output of this block is given a default first, so no latch can be inferred.
   always_comb begin
      stateNext     = state;
      counterLoad   = 1'b0;
      counterEnable = 1'b0;
      capturePc     = 1'b0;
      case (state)
         IDLE: begin
            if (flagExecProc && multiprogOn && quantumNonZero) begin
               counterLoad = 1'b1;
               stateNext   = RUN;
            end
         end
         RUN: begin
            // A stalled processor freezes the quantum; a fresh EXEC restarts it (never with zero).
            if (!interruption) begin
               if (flagExecProc && quantumNonZero) begin
                  counterLoad = 1'b1;
               end else if (counterTerminal) begin
                  counterEnable = 1'b1;
                  stateNext     = SWITCH;
               end else begin
                  counterEnable = 1'b1;
               end
            end
         end
         SWITCH: begin
            // The control unit serves the interruption first, so the switch waits for it.
            if (!interruption) begin
               capturePc = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   quantum_counter #(
      .QUANTUM_WIDTH(QUANTUM_WIDTH)
   ) counterInst (
      .clock    (clock),
      .reset    (reset),
      .load     (counterLoad),
      .enable   (counterEnable),
      .loadValue(quantumReg),
      .terminal (counterTerminal)
   );

   assign flagCS  = (state == SWITCH);
   assign running = (state == RUN);

endmodule
